mux_nway_pipe: RTL
==================

Name: mux_nway_pipe

Overview:
- Parametrised successor to the 16-bit 4-way mux: selects one of WAYS input channels of WIDTH bits and registers the result in a one-entry output buffer.
- Each input and the output use a valid/ready handshake.
- Two selection modes: explicit select (sel port) or round-robin arbitration among valid channels.
- Sits between producer datapaths and a single consumer, for example a shared bus or ALU operand port.

Parameters:
- WIDTH, 16, data bits per channel (1..64).
- WAYS, 4, number of input channels; power of two, 2..16.
- SEL_W, $clog2(WAYS), select/channel-index width; derived, never overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = explicit select via sel; 1 = round-robin among valid inputs.
- sel  in  SEL_W  channel index used when mode=0.
- in_data  in  WAYS*WIDTH  flattened inputs; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  WAYS  per-channel valid.
- in_ready  out  WAYS  per-channel ready; at most one bit high.
- out_data  out  WIDTH  registered selected word.
- out_chan  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  out_data/out_chan hold a word.
- out_ready  in  1  consumer accepts the word this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=WAYS-1, so channel 0 has first priority after reset.
- Reset mid-operation: any buffered word is discarded. No in_ready is high while reset is asserted.
- accept = !out_valid || out_ready (combinational). The buffer may load only when accept=1.
- Grant, mode=0: grant=sel. Channel sel sees in_ready=accept; all other in_ready bits are 0. sel is not checked against in_valid.
- Grant, mode=1: grant is the first i with in_valid[i]=1, scanning last+1, last+2, … modulo WAYS.
  - If no input is valid, there is no grant and all in_ready bits are 0.
  - in_ready[grant]=accept.
- Transfer occurs on a rising edge when in_valid[grant] && in_ready[grant]. On transfer:
  - out_data <= channel grant data.
  - out_chan <= grant.
  - out_valid <= 1.
  - In mode=1 only: last <= grant.
- Drain: out_valid && out_ready with no new transfer -> out_valid <= 0. out_data and out_chan keep their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old; out_valid stays 1. Full throughput is 1 word/cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_chan and out_valid are held stable and all in_ready bits are 0.
- Latency: one cycle from the input handshake to out_valid.
- Mode/select changes:
  - mode and sel are sampled combinationally every cycle; changing either between words is legal.
  - last is kept across mode changes and only updates on mode=1 transfers.
- Round-robin fairness: with all WAYS inputs continuously valid and out_ready=1, grants cycle 0,1,…,WAYS-1,0,…; no channel waits more than WAYS-1 transfers.
- in_ready depends combinationally on out_ready, in_valid, mode and sel. There is no combinational path from in_data to any output.
- No data width conversion: the word is copied bit-exact.

Test Plan:
- Reset, mode=0, sel=2, in_valid=4'b0100, channel 2 = 16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=16'hBEEF, out_chan=2.
- mode=0, sel=1, in_valid[1]=0, other channels valid -> in_ready=4'b0010; no transfer; out_valid stays 0.
- mode=1, all valid, channel data 16'h000i, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3; out_data follows it; out_valid=1 each cycle after the first.
- Load 16'h1234, then out_ready=0 for 3 cycles with inputs valid -> out_data=16'h1234 held, all in_ready=0; then out_ready=1 -> next word loads in that same cycle (drain+load), out_valid stays 1.
- mode=1, only channels 1 and 3 valid, last=1 -> grant 3 then 1 alternately; after a switch to mode=0 with sel=0 and back to mode=1, the next grant follows from the preserved last.
- Assert reset while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0, out_chan=0 immediately, without a clock edge; first mode=1 grant after release is the lowest-index valid channel.

Source files
------------

// File: rtl/mux_nway_pipe.sv
// WAYS-to-1 channel selector with valid/ready handshakes and a one-entry output buffer.
// Channel choice is either an explicit index or round-robin among valid inputs.
module mux_nway_pipe #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 4,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [WAYS*WIDTH-1:0]   in_data,
  input  logic [WAYS-1:0]         in_valid,
  output logic [WAYS-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_chan_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] last_r;

  logic             accept_s;
  logic [SEL_W-1:0] rr_grant_s;
  logic             rr_found_s;
  logic [SEL_W-1:0] grant_s;
  logic             grant_ok_s;
  logic [WAYS-1:0]  in_ready_s;
  logic             xfer_s;

  assign accept_s = !out_valid_r || out_ready;

  // Round-robin scan starting just after the last granted channel; index arithmetic wraps since WAYS is a power of two.
  always_comb begin
    logic [SEL_W-1:0] idx_v;
    rr_found_s = 1'b0;
    rr_grant_s = '0;
    idx_v      = '0;
    for (int k = 1; k <= WAYS; k++) begin
      idx_v = last_r + k[SEL_W-1:0];
      if (!rr_found_s && in_valid[idx_v]) begin
        rr_found_s = 1'b1;
        rr_grant_s = idx_v;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant and ready generation.
  always_comb begin
    grant_s    = '0;
    grant_ok_s = 1'b0;
    in_ready_s = '0;
    if (mode) begin
      grant_s    = rr_grant_s;
      grant_ok_s = rr_found_s;
    end else begin
      grant_s    = sel;
      grant_ok_s = 1'b1;
    end
    if (grant_ok_s && accept_s && !reset) begin
      in_ready_s[grant_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  assign xfer_s   = grant_ok_s && in_valid[grant_s] && in_ready_s[grant_s];
  assign in_ready = in_ready_s;

  // Output buffer: load on transfer, otherwise drain when the consumer takes the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r  <= '0;
      out_chan_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (xfer_s) begin
      out_data_r  <= in_data[grant_s*WIDTH +: WIDTH];
      out_chan_r  <= grant_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer moves only on round-robin transfers so it survives explicit-select phases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r <= SEL_W'(WAYS - 1);
    end else if (xfer_s && mode) begin
      last_r <= grant_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule
